// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_pkg
//  Description : Shared pipeline definitions for the hazard stall/flush unit:
//                mul/div FSM state encoding, the zero-register constant, the
//                stall counter width and a register-hit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 32;

  // A writer hits a source register when it writes that register and the
  // register is not the hard-wired zero register.
  function automatic logic reg_hit(input logic       wr,
                                   input logic [4:0] waddr,
                                   input logic [4:0] r);
    return wr && (waddr == r) && (r != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : Pipeline <-> hazard unit bundle. The master side is the
//                pipeline (drives stage information, receives controls); the
//                slave side is the hazard stall unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if;
  import hazard_stall_unit_pkg::*;

  // ID-stage operand information
  logic [4:0] rs_ID;
  logic [4:0] rt_ID;
  logic       use_rs_ID;
  logic       use_rt_ID;
  logic       Branch_ID;
  logic       JumpReg_ID;
  logic       Jump_ID;
  logic       BranchTaken_ID;

  // Writers in EX and MEM
  logic [4:0] REG_WRITE_ADDR_EX;
  logic [4:0] REG_WRITE_ADDR_MEM;
  logic       RegWr_EX;
  logic       MemRd_EX;
  logic       RegWr_MEM;
  logic       MemRd_MEM;
  logic       MulDiv_EX;

  // Controls back to the pipeline
  logic       PCWr;
  logic       IFIDWr;
  logic       IDEXWr;
  logic       IFID_Flush;
  logic       IDEX_Flush;
  logic       EXMEM_Flush;
  logic       MD_busy;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, Branch_ID, JumpReg_ID,
           Jump_ID, BranchTaken_ID, REG_WRITE_ADDR_EX, REG_WRITE_ADDR_MEM,
           RegWr_EX, MemRd_EX, RegWr_MEM, MemRd_MEM, MulDiv_EX,
    input  PCWr, IFIDWr, IDEXWr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MD_busy, stall_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, Branch_ID, JumpReg_ID,
           Jump_ID, BranchTaken_ID, REG_WRITE_ADDR_EX, REG_WRITE_ADDR_MEM,
           RegWr_EX, MemRd_EX, RegWr_MEM, MemRd_MEM, MulDiv_EX,
    output PCWr, IFIDWr, IDEXWr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MD_busy, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit_md_stall_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : md_stall_fsm
//  Description : Mul/div occupancy tracker. Holds the pipeline for exactly
//                MD_LATENCY cycles per mul/div, then spends one DONE cycle in
//                which MulDiv_EX is ignored so the same op cannot restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_stall_fsm
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mul_div_ex,
  output logic md_stall
);

  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  localparam logic [1:0]       ST_IDLE  = MD_IDLE;
  localparam logic [1:0]       ST_BUSY  = MD_BUSY;
  localparam logic [1:0]       ST_DONE  = MD_DONE;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next-state and countdown: the IDLE cycle that sees the op is the first
  // stall cycle, so BUSY only has to cover the remaining MD_LATENCY-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (mul_div_ex) begin
          w_cnt_nxt   = LOAD_VAL;
          w_state_nxt = (MD_LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign md_stall = ((r_state == ST_IDLE) && mul_div_ex) || (r_state == ST_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Stall/flush controller for the five-stage pipeline. Covers
//                load-use, stale ID-stage branch/jr operands and (optionally)
//                multi-cycle mul/div occupancy of EX. Keeps a free-running
//                count of cycles in which the PC was held.
//                Optional feature macro: HAZARD_MULDIV_EN (mul/div stall FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_unit_if.slave   bus
);

  logic w_ld_stall;
  logic w_br_stall;
  logic w_rs_stale;
  logic w_rt_stale;
  logic w_id_stall;
  logic w_md_stall;
  logic w_any_stall;
  logic w_redirect;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Load-use: only a load in EX cannot be bypassed into EX next cycle.
  assign w_ld_stall = rst_n & bus.MemRd_EX &
      ((bus.use_rs_ID & reg_hit(bus.RegWr_EX, bus.REG_WRITE_ADDR_EX, bus.rs_ID)) |
       (bus.use_rt_ID & reg_hit(bus.RegWr_EX, bus.REG_WRITE_ADDR_EX, bus.rt_ID)));

  // ID compare operands are stale if any EX writer targets them, or a load
  // in MEM does (its data only arrives at the end of MEM).
  assign w_rs_stale = reg_hit(bus.RegWr_EX, bus.REG_WRITE_ADDR_EX, bus.rs_ID) |
      (bus.MemRd_MEM & reg_hit(bus.RegWr_MEM, bus.REG_WRITE_ADDR_MEM, bus.rs_ID));
  assign w_rt_stale = reg_hit(bus.RegWr_EX, bus.REG_WRITE_ADDR_EX, bus.rt_ID) |
      (bus.MemRd_MEM & reg_hit(bus.RegWr_MEM, bus.REG_WRITE_ADDR_MEM, bus.rt_ID));

  assign w_br_stall = rst_n &
      (((bus.Branch_ID | bus.JumpReg_ID) & w_rs_stale) | (bus.Branch_ID & w_rt_stale));

  assign w_id_stall = w_ld_stall | w_br_stall;

`ifdef HAZARD_MULDIV_EN
  logic w_md_raw;

  md_stall_fsm #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_stall_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mul_div_ex (bus.MulDiv_EX),
    .md_stall   (w_md_raw)
  );

  // Controls must read as "run" while reset is held, whatever EX shows.
  assign w_md_stall = rst_n & w_md_raw;
`else
  logic w_unused_md;

  assign w_unused_md = &{1'b0, bus.MulDiv_EX, MD_LATENCY[0]};
  assign w_md_stall  = 1'b0;
`endif

  assign w_any_stall = w_md_stall | w_id_stall;
  assign w_redirect  = bus.BranchTaken_ID | bus.Jump_ID | bus.JumpReg_ID;

  // Mul/div freezes everything up to EX and bubbles MEM; it outranks the ID
  // stall, so ID/EX is held rather than flushed while it is active.
  assign bus.PCWr        = ~w_any_stall;
  assign bus.IFIDWr      = ~w_any_stall;
  assign bus.IDEXWr      = ~w_md_stall;
  assign bus.IDEX_Flush  = w_id_stall & ~w_md_stall;
  assign bus.EXMEM_Flush = w_md_stall;
  assign bus.MD_busy     = w_md_stall;
  assign bus.IFID_Flush  = rst_n & w_redirect & ~w_any_stall;
  assign bus.stall_cnt   = r_stall_cnt;

  // Count every cycle the PC is held; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_any_stall) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the five-stage pipeline; the counterpart of the EX-stage forwarding logic. It covers the hazards that bypassing cannot resolve: load-use, ID-stage branch/jr operands not yet available, and multi-cycle mul/div occupancy of EX. It drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls and keeps a free-running stall-cycle counter.

## Interface
- MD_LATENCY, 4, EX cycles for a mul/div operation (≥1)
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- rs_ID, rt_ID  in  5  ID-stage source registers
- use_rs_ID, use_rt_ID  in  1  ID instruction reads rs / rt
- Branch_ID  in  1  branch compared in ID (needs rs and rt)
- JumpReg_ID  in  1  jr/jalr in ID (needs rs)
- Jump_ID, BranchTaken_ID  in  1  redirect decided in ID
- REG_WRITE_ADDR_EX, REG_WRITE_ADDR_MEM  in  5  destination registers
- RegWr_EX, MemRd_EX, RegWr_MEM, MemRd_MEM  in  1  writeback / load flags
- MulDiv_EX  in  1  mul/div in EX
- PCWr, IFIDWr, IDEXWr  out  1  stage write enables
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1  bubble inserts
- MD_busy  out  1  mul/div stall active
- stall_cnt  out  32  cycles with PCWr=0

## Operation
- Register 0 never causes a hazard.
- hitEX(r) = RegWr_EX & REG_WRITE_ADDR_EX==r & r!=0. hitMEM(r) is the same using the MEM fields.
- ld_stall = MemRd_EX & ((use_rs_ID & hitEX(rs_ID)) | (use_rt_ID & hitEX(rt_ID))).
- br_stall: the ID compare operand (rs for JumpReg_ID; rs and rt for Branch_ID) has hitEX from any writer, or hitMEM with MemRd_MEM.
- A load feeding a branch/jr therefore stalls 2 cycles. An ALU result feeding a branch/jr stalls 1 cycle.
- ID stall (ld_stall|br_stall): PCWr=0, IFIDWr=0, IDEX_Flush=1.
- Mul/div FSM states:
  - IDLE: if MulDiv_EX, load cnt=MD_LATENCY-1 and go to BUSY; go to DONE directly if MD_LATENCY==1.
  - BUSY: cnt decrements each cycle; at cnt==1 go to DONE.
  - DONE: always go to IDLE. MulDiv_EX is ignored here, so the same instruction does not restart.
- md_stall = (IDLE & MulDiv_EX) | BUSY. MD_busy = md_stall.
- During md_stall: PCWr=IFIDWr=IDEXWr=0, EXMEM_Flush=1, IDEX_Flush=0. md_stall takes priority over ID stall.
- IFID_Flush = (BranchTaken_ID|Jump_ID|JumpReg_ID) & ~any_stall. A redirect is never acted on while its operands are stale.
- stall_cnt increments on every cycle with PCWr==0 and wraps at 2^32-1 → 0.
- Back-to-back mul/div: the second enters EX on the cycle after DONE and starts from IDLE.

## Timing
- Stall/flush outputs are combinational from the current state and inputs, valid in the same cycle.
- FSM state, cnt and stall_cnt are registered on the clk rising edge.
- A mul/div holds the pipeline for exactly MD_LATENCY cycles and releases in DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, stall_cnt=0 immediately.
  - While reset is held: PCWr=IFIDWr=IDEXWr=1, all flushes 0, MD_busy=0, regardless of inputs.
  - Reset asserted mid-BUSY abandons the operation; no DONE cycle follows.

## Configuration
- HAZARD_MULDIV_EN defined: mul/div FSM, MD_latency stall, MD_busy and EXMEM_Flush behave as above.
- Undefined: FSM and cnt are not built. MulDiv_EX and MD_LATENCY are ignored. MD_busy=0, EXMEM_Flush=0, IDEXWr=1 always. Load/branch stalls and stall_cnt are unchanged.

## Structure
- Shared pipeline package holds:
  - md_state_t enum (MD_IDLE, MD_BUSY, MD_DONE)
  - REG_ZERO constant (5'd0)
  - stall counter width constant (32)
- Sub-module md_stall_fsm (FSM + cnt, outputs md_stall) is instantiated only under HAZARD_MULDIV_EN.

## Test plan
- Load-use stall:
  - Stimulus: MemRd_EX=1, RegWr_EX=1, REG_WRITE_ADDR_EX=8; ID rs_ID=8, use_rs_ID=1.
  - Response: one cycle of PCWr=0, IFIDWr=0, IDEX_Flush=1. Next cycle (load now in MEM, ID still an ALU op) no stall. stall_cnt +1.
- Register-0 load:
  - Stimulus: same as above with REG_WRITE_ADDR_EX=0, rs_ID=0.
  - Response: PCWr=1, no flush.
- ALU result feeding a branch:
  - Stimulus: Branch_ID=1, rs_ID=9, BranchTaken_ID=1; EX ALU writes reg 9.
  - Response: 1 stall cycle with IFID_Flush=0. Following cycle IFID_Flush=1, PCWr=1.
- Load feeding jr:
  - Stimulus: load to reg 10 in EX, JumpReg_ID=1, rs_ID=10.
  - Response: 2 stall cycles (EX hit, then MEM load hit), then IFID_Flush=1.
- Mul/div occupancy (HAZARD_MULDIV_EN, MD_LATENCY=4):
  - Stimulus: MulDiv_EX held high for 5 cycles.
  - Response: 4 cycles of MD_busy=1, IDEXWr=0, EXMEM_Flush=1; DONE cycle releases with no restart; stall_cnt +4.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during BUSY cycle 2.
  - Response: immediately MD_busy=0, stall_cnt=0, PCWr=1. After release with MulDiv_EX=0, remains IDLE.
